deframer: RTL

DEFRAMER -- requirements
Module: deframer

---
 rtl/frame_pkg.sv | 15 +
 rtl/deframe_unpack.sv | 50 +++++
 rtl/deframer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Tail byte definitions and deframer state encoding shared between the
// framer and the deframer so both sides agree on the frame trailer.
package frame_pkg;

   localparam logic [7:0] TAIL_BYTE0 = 8'h0D;
   localparam logic [7:0] TAIL_BYTE1 = 8'h0A;

   typedef enum logic [1:0] {
      ST_PAYLOAD = 2'd0,
      ST_TAIL0   = 2'd1,
      ST_TAIL1   = 2'd2,
      ST_RESYNC  = 2'd3
   } deframer_state_e;

endpackage

// File: rtl/deframe_unpack.sv
// Holds one accepted byte and shifts it out element by element, LSB first.
// The FSM loads it with the number of elements this byte contributes.
module deframe_unpack #(
   parameter int  UnpackedWidth = 1,
   parameter int  PackedNum     = 8,
   localparam int NumW          = $clog2(PackedNum + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     load_i,
   input  logic [7:0]               data_i,
   input  logic [NumW-1:0]          load_num_i,
   input  logic                     pop_i,
   output logic                     held_o,
   output logic                     final_o,
   output logic [UnpackedWidth-1:0] elem_o
);

   logic [7:0]      shift_q, shift_d;
   logic [NumW-1:0] left_q, left_d;

   assign held_o  = (left_q != '0);
   assign final_o = (left_q == NumW'(1));
   assign elem_o  = shift_q[UnpackedWidth-1:0];

   // A load in the same cycle as the final pop overwrites the drained byte.
   always_comb begin
      shift_d = shift_q;
      left_d  = left_q;
      if (pop_i && held_o) begin
         shift_d = shift_q >> UnpackedWidth;
         left_d  = left_q - NumW'(1);
      end
      if (load_i) begin
         shift_d = data_i;
         left_d  = load_num_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shift_q <= '0;
         left_q  <= '0;
      end else begin
         shift_q <= shift_d;
         left_q  <= left_d;
      end
   end

endmodule

// File: rtl/deframer.sv
// Byte-stream deframer: unpacks a fixed-length payload into elements, then
// checks a two-byte tail and hunts for the tail pair after a mismatch.
//
// state   | meaning
// --------+------------------------------------------------------------
// PAYLOAD | accepting payload bytes, emitting elements
// TAIL0   | waiting for first tail byte
// TAIL1   | waiting for second tail byte
// RESYNC  | hunting for TailByte0,TailByte1 pair (armed_q = saw TailByte0)
module deframer
   import frame_pkg::*;
#(
   parameter int         UnpackedWidth  = 1,
   parameter int         PackedNum      = 8,
   parameter int         PacketLenElems = 318 * 238,
   parameter logic [7:0] TailByte0      = TAIL_BYTE0,
   parameter logic [7:0] TailByte1      = TAIL_BYTE1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [7:0]               data_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   output logic [UnpackedWidth-1:0] unpacked_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic                     last_o,
   output logic                     frame_ok_o,
   output logic                     frame_err_o
);

   localparam int              CntW   = $clog2(PacketLenElems + 1);
   localparam int              NumW   = $clog2(PackedNum + 1);
   localparam logic [CntW-1:0] LenCnt = CntW'(PacketLenElems);

   deframer_state_e state_q;
   logic [CntW-1:0] loaded_q;
   logic            armed_q;
   logic            frame_ok_q;
   logic            frame_err_q;

   logic            held;
   logic            final_elem;
   logic            pop;
   logic            accept;
   logic            load;
   logic            all_loaded;
   logic [31:0]     remain;
   logic [NumW-1:0] load_num;

   assign all_loaded = (loaded_q == LenCnt);
   assign pop        = held & ready_i;
   assign ready_o    = (state_q != ST_PAYLOAD) | ~held | (pop & final_elem);
   assign accept     = valid_i & ready_o;
   assign load       = accept & (state_q == ST_PAYLOAD) & ~all_loaded;

   // The final payload byte only contributes the elements still owed.
   assign remain   = 32'(PacketLenElems) - 32'(loaded_q);
   assign load_num = (remain >= 32'(PackedNum)) ? NumW'(PackedNum) : NumW'(remain);

   deframe_unpack #(
      .UnpackedWidth (UnpackedWidth),
      .PackedNum     (PackedNum)
   ) u_unpack (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (load),
      .data_i     (data_i),
      .load_num_i (load_num),
      .pop_i      (pop),
      .held_o     (held),
      .final_o    (final_elem),
      .elem_o     (unpacked_o)
   );

   assign valid_o     = held;
   assign last_o      = held & final_elem & all_loaded;
   assign frame_ok_o  = frame_ok_q;
   assign frame_err_o = frame_err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_PAYLOAD;
         loaded_q    <= '0;
         armed_q     <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         unique case (state_q)
            ST_PAYLOAD: begin
               // A byte accepted while the last element drains is the first tail byte.
               if (accept && all_loaded) begin
                  loaded_q <= '0;
                  if (data_i == TailByte0) begin
                     state_q <= ST_TAIL1;
                  end else begin
                     frame_err_q <= 1'b1;
                     armed_q     <= 1'b0;
                     state_q     <= ST_RESYNC;
                  end
               end else if (accept) begin
                  loaded_q <= CntW'(32'(loaded_q) + 32'(load_num));
               end else if (last_o && ready_i) begin
                  loaded_q <= '0;
                  state_q  <= ST_TAIL0;
               end
            end
            ST_TAIL0: begin
               if (accept) begin
                  if (data_i == TailByte0) begin
                     state_q <= ST_TAIL1;
                  end else begin
                     frame_err_q <= 1'b1;
                     armed_q     <= 1'b0;
                     state_q     <= ST_RESYNC;
                  end
               end
            end
            ST_TAIL1: begin
               if (accept) begin
                  if (data_i == TailByte1) begin
                     frame_ok_q <= 1'b1;
                     state_q    <= ST_PAYLOAD;
                  end else begin
                     frame_err_q <= 1'b1;
                     armed_q     <= 1'b0;
                     state_q     <= ST_RESYNC;
                  end
               end
            end
            ST_RESYNC: begin
               if (accept) begin
                  if (armed_q && (data_i == TailByte1)) begin
                     armed_q <= 1'b0;
                     state_q <= ST_PAYLOAD;
                  end else begin
                     armed_q <= (data_i == TailByte0);
                  end
               end
            end
            default: state_q <= ST_PAYLOAD;
         endcase
      end
   end

endmodule
